// File: rtl/snax_gemm_reader_pkg.sv
// Shared definitions for the SNAX GEMM TCDM operand reader.
//   - rd_state_e      : reader FSM states
//   - Def*            : default parameter values for the reader top
//   - DefBytesPerWord : byte stride between neighbouring TCDM ports
package snax_gemm_reader_pkg;

  localparam int unsigned DefDataWidth    = 64;
  localparam int unsigned DefNumPorts     = 8;
  localparam int unsigned DefAddrWidth    = 17;
  localparam int unsigned DefCntWidth     = 16;
  localparam int unsigned DefBytesPerWord = DefDataWidth / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_OUT  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/snax_gemm_reader_port.sv
// Per-port request/response bookkeeping for the TCDM reader.
// Tracks whether this port's read for the current block has been granted
// and answered, and holds the returned data word until the block is consumed.
// Ports:
//   clk_i, rst_i   clock, async active-high reset
//   clr_i          start of a new block: drop granted/received flags
//   active_i       reader is in its request phase
//   q_valid_o      request valid (active and not yet granted)
//   q_ready_i      TCDM grant for this port
//   p_valid_i      TCDM response valid, p_data_i response word
//   received_o     response for the current block has been captured
//   data_o         captured response word
module snax_gemm_reader_port
  import snax_gemm_reader_pkg::*;
#(
  parameter int unsigned DataWidth = DefDataWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 active_i,
  output logic                 q_valid_o,
  input  logic                 q_ready_i,
  input  logic                 p_valid_i,
  input  logic [DataWidth-1:0] p_data_i,
  output logic                 received_o,
  output logic [DataWidth-1:0] data_o
);

  logic                 granted_q, granted_d;
  logic                 received_q, received_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 capture;

  assign q_valid_o = active_i & ~granted_q;
  // Only an outstanding read may be answered; stray responses are dropped.
  assign capture   = active_i & p_valid_i & granted_q & ~received_q;

  always_comb begin
    granted_d  = granted_q;
    received_d = received_q;
    data_d     = data_q;
    if (clr_i) begin
      granted_d  = 1'b0;
      received_d = 1'b0;
    end else begin
      if (q_valid_o && q_ready_i) granted_d = 1'b1;
      if (capture) begin
        received_d = 1'b1;
        data_d     = p_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      granted_q  <= 1'b0;
      received_q <= 1'b0;
      data_q     <= '0;
    end else begin
      granted_q  <= granted_d;
      received_q <= received_d;
      data_q     <= data_d;
    end
  end

  assign received_o = received_q;
  assign data_o     = data_q;

endmodule

// File: rtl/snax_gemm_tcdm_reader.sv
// Operand-fetch stage for the SNAX GEMM datapath.
// Fetches num_blocks_i strided blocks; each block is one read per TCDM port
// (port i at block address + i*DataWidth/8). Responses may return in any
// order; the assembled wide word is offered to the GEMM core on out_valid_o /
// out_ready_i. Only one block is in flight at a time.
// Ports:
//   clk_i, rst_i                  clock, async active-high reset
//   start_i, base_addr_i,
//   stride_i, num_blocks_i        launch command (sampled in IDLE only)
//   busy_o, done_o                status; done_o pulses after the last block
//   tcdm_q_*                      per-port read request channel
//   tcdm_p_*                      per-port read response channel
//   out_valid_o, out_data_o,
//   out_ready_i                   assembled operand word to the GEMM core
//   stall_cnt_o                   stall cycle counter, present only when
//                                 SNAX_GEMM_READER_PERF_CNT_EN is defined
module snax_gemm_tcdm_reader
  import snax_gemm_reader_pkg::*;
#(
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned NumPorts  = DefNumPorts,
  parameter int unsigned AddrWidth = DefAddrWidth,
  parameter int unsigned CntWidth  = DefCntWidth
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [AddrWidth-1:0]          base_addr_i,
  input  logic [AddrWidth-1:0]          stride_i,
  input  logic [CntWidth-1:0]           num_blocks_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [NumPorts-1:0]           tcdm_q_valid_o,
  output logic [NumPorts*AddrWidth-1:0] tcdm_q_addr_o,
  input  logic [NumPorts-1:0]           tcdm_q_ready_i,
  input  logic [NumPorts-1:0]           tcdm_p_valid_i,
  input  logic [NumPorts*DataWidth-1:0] tcdm_p_data_i,
  output logic                          out_valid_o,
  output logic [NumPorts*DataWidth-1:0] out_data_o,
  input  logic                          out_ready_i
`ifdef SNAX_GEMM_READER_PERF_CNT_EN
  ,
  output logic [CntWidth-1:0]           stall_cnt_o
`endif
);

  localparam int unsigned BytesPerWord = DataWidth / 8;

  rd_state_e            state_q, state_d;
  logic [CntWidth-1:0]  blk_q, blk_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [AddrWidth-1:0] stride_q, stride_d;
  logic [AddrWidth-1:0] blk_addr_q, blk_addr_d;
  logic                 done_q, done_d;

  logic                 start_acc, launch, hs, last_blk, clr_masks, req_active;
  logic [NumPorts-1:0]  received;

  assign start_acc = (state_q == ST_IDLE) && start_i;
  assign launch    = start_acc && (num_blocks_i != '0);
  assign hs        = (state_q == ST_OUT) && out_ready_i;
  assign last_blk  = (blk_q == (cnt_q - CntWidth'(1)));
  assign clr_masks = launch || (hs && !last_blk);

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (launch) state_d = ST_REQ;
      ST_REQ:  if (&received) state_d = ST_OUT;
      ST_OUT:  if (out_ready_i) state_d = last_blk ? ST_IDLE : ST_REQ;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o      = (state_q != ST_IDLE);
    req_active  = (state_q == ST_REQ);
    out_valid_o = (state_q == ST_OUT);
  end

  // Block bookkeeping. The block address is kept as a running sum so no
  // multiplier is needed; it wraps modulo 2^AddrWidth by truncation.
  always_comb begin
    blk_d      = blk_q;
    cnt_d      = cnt_q;
    stride_d   = stride_q;
    blk_addr_d = blk_addr_q;
    done_d     = (start_acc && (num_blocks_i == '0)) || (hs && last_blk);
    if (launch) begin
      blk_d      = '0;
      cnt_d      = num_blocks_i;
      stride_d   = stride_i;
      blk_addr_d = base_addr_i;
    end else if (hs && !last_blk) begin
      blk_d      = blk_q + CntWidth'(1);
      blk_addr_d = blk_addr_q + stride_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      blk_q      <= '0;
      cnt_q      <= '0;
      stride_q   <= '0;
      blk_addr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      blk_q      <= blk_d;
      cnt_q      <= cnt_d;
      stride_q   <= stride_d;
      blk_addr_q <= blk_addr_d;
      done_q     <= done_d;
    end
  end

  assign done_o = done_q;

  for (genvar g = 0; g < NumPorts; g++) begin : g_port
    logic [AddrWidth-1:0] port_addr;
    assign port_addr = blk_addr_q + AddrWidth'(g * BytesPerWord);
    // Address only driven during the request phase; it cannot move there
    // because blk_addr_q only changes on launch or output handshake.
    assign tcdm_q_addr_o[g*AddrWidth +: AddrWidth] = req_active ? port_addr : '0;

    snax_gemm_reader_port #(
      .DataWidth (DataWidth)
    ) u_port (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (clr_masks),
      .active_i   (req_active),
      .q_valid_o  (tcdm_q_valid_o[g]),
      .q_ready_i  (tcdm_q_ready_i[g]),
      .p_valid_i  (tcdm_p_valid_i[g]),
      .p_data_i   (tcdm_p_data_i[g*DataWidth +: DataWidth]),
      .received_o (received[g]),
      .data_o     (out_data_o[g*DataWidth +: DataWidth])
    );
  end

`ifdef SNAX_GEMM_READER_PERF_CNT_EN
  logic [CntWidth-1:0] stall_q, stall_d;
  logic                stall_evt;

  assign stall_evt = (req_active && |(tcdm_q_valid_o & ~tcdm_q_ready_i)) ||
                     (out_valid_o && !out_ready_i);

  always_comb begin
    stall_d = stall_q;
    if (start_acc)                    stall_d = '0;
    else if (stall_evt && !(&stall_q)) stall_d = stall_q + CntWidth'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_snax_gemm_tcdm_reader.sv
module tb_snax_gemm_tcdm_reader;
  localparam int NP = 8;
  localparam int DW = 64;
  localparam int AW = 17;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [AW-1:0]     base, stride;
  logic [CW-1:0]     num;
  logic              busy, done;
  logic [NP-1:0]     q_valid, q_ready, p_valid;
  logic [NP*AW-1:0]  q_addr;
  logic [NP*DW-1:0]  p_data, out_data;
  logic              out_valid, out_ready;
`ifdef SNAX_GEMM_READER_PERF_CNT_EN
  logic [CW-1:0]     stall_cnt;
`endif

  always #5 clk = ~clk;

  snax_gemm_tcdm_reader dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .base_addr_i    (base),
    .stride_i       (stride),
    .num_blocks_i   (num),
    .busy_o         (busy),
    .done_o         (done),
    .tcdm_q_valid_o (q_valid),
    .tcdm_q_addr_o  (q_addr),
    .tcdm_q_ready_i (q_ready),
    .tcdm_p_valid_i (p_valid),
    .tcdm_p_data_i  (p_data),
    .out_valid_o    (out_valid),
    .out_data_o     (out_data),
    .out_ready_i    (out_ready)
`ifdef SNAX_GEMM_READER_PERF_CNT_EN
    ,
    .stall_cnt_o    (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response payload is a fixed function of the read address.
  function automatic logic [63:0] dfn(input logic [AW-1:0] a);
    return {32'hCAFE_0000 ^ {15'h0, a}, {12'h0, a, 3'b101}};
  endfunction

  // ---------------- TCDM memory model ----------------
  // Acts at the falling edge: sees the request/ready pair that the next
  // rising edge will grant, and answers one full cycle after that grant.
  logic [NP-1:0]    pend = '0, held = '0;
  logic [AW-1:0]    pend_addr [NP];
  logic [AW-1:0]    held_addr [NP];
  int               grants [NP];
  int               addr_unstable = 0;
  int               req_in_out = 0;
  logic [NP-1:0]    inj_mask;
  logic [NP*DW-1:0] inj_data;

  initial for (int i = 0; i < NP; i++) grants[i] = 0;

  always @(negedge clk) begin
    logic [NP-1:0]    pv;
    logic [NP*DW-1:0] pd;
    pv = inj_mask;
    pd = inj_data;
    for (int i = 0; i < NP; i++)
      if (pend[i]) begin
        pv[i] = 1'b1;
        pd[i*DW +: DW] = dfn(pend_addr[i]);
        pend[i] = 1'b0;
      end
    if (!rst) begin
      for (int i = 0; i < NP; i++) begin
        if (q_valid[i]) begin
          if (held[i] && q_addr[i*AW +: AW] !== held_addr[i]) addr_unstable++;
          if (q_ready[i]) begin
            pend[i] = 1'b1;
            pend_addr[i] = q_addr[i*AW +: AW];
            grants[i]++;
            held[i] = 1'b0;
          end else begin
            held[i] = 1'b1;
            held_addr[i] = q_addr[i*AW +: AW];
          end
        end else held[i] = 1'b0;
      end
      if (q_valid != '0 && out_valid) req_in_out++;
    end
    p_valid = pv;
    p_data  = pd;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] stride;
    logic [CW-1:0] count;
    int            bp_port;   // port held not-ready at start, -1 none
    int            bp_cyc;    // cycles that port stays not-ready
    int            ostall;    // cycles out_ready_i stays low per block
    int            lat;       // start -> out_valid_o cycles, first block
    logic [AW-1:0] p1_addr;   // port 1 address of block 0
    int            stall;     // expected stall counter at end
  } vec_t;

  vec_t vt [4];

  task automatic run_vec(input vec_t v);
    int            g0 [NP];
    int            rio0, lat, n;
    logic [AW-1:0] bb;
    for (int i = 0; i < NP; i++) g0[i] = grants[i];
    rio0 = req_in_out;
    q_ready = (v.bp_port >= 0) ? ~(NP'(1) << v.bp_port) : '1;
    base = v.base; stride = v.stride; num = v.count; start = 1'b1;
    tick();
    start = 1'b0;
    chk("req_valid_all", q_valid, {NP{1'b1}});
    chk("busy_in_req", busy, 1);
    chk("addr_p1_hand", q_addr[AW +: AW], v.p1_addr);
    for (int i = 0; i < NP; i++)
      chk($sformatf("addr_p%0d", i), q_addr[i*AW +: AW], AW'(v.base + AW'(i*8)));
    lat = 0;
    if (v.bp_port >= 0) begin
      repeat (v.bp_cyc) begin tick(); lat++; end
      chk("bp_port_still_valid", q_valid[v.bp_port], 1);
      chk("bp_no_out_early", out_valid, 0);
      q_ready = '1;
    end
    while (!out_valid && lat < 60) begin tick(); lat++; end
    chk("latency", lat, v.lat);
    if (!out_valid) return;
    for (int b = 0; b < int'(v.count); b++) begin
      if (b > 0) begin
        n = 0;
        while (!out_valid && n < 60) begin tick(); n++; end
        chk("blk_out_valid", out_valid, 1);
        if (!out_valid) return;
      end
      bb = v.base + v.stride * AW'(b);
      for (int i = 0; i < NP; i++)
        chk($sformatf("data_b%0d_p%0d", b, i), out_data[i*DW +: DW], dfn(AW'(bb + AW'(i*8))));
      repeat (v.ostall) tick();
      chk("out_valid_hold", out_valid, 1);
      chk("out_data_stable", out_data[DW +: DW], dfn(AW'(bb + AW'(8))));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      if (b == int'(v.count) - 1) begin
        chk("done_pulse", done, 1);
        chk("busy_low_at_done", busy, 0);
        tick();
        chk("done_cleared", done, 0);
      end else begin
        chk("no_done_mid", done, 0);
        chk("busy_mid", busy, 1);
      end
    end
    for (int i = 0; i < NP; i++)
      chk($sformatf("grants_p%0d", i), grants[i] - g0[i], v.count);
    chk("no_req_in_out", req_in_out - rio0, 0);
    chk("addr_stable", addr_unstable, 0);
`ifdef SNAX_GEMM_READER_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, v.stall);
`endif
  endtask

  initial begin
    int g0, n;
    vt[0] = '{17'h00100, 17'h00040, 16'd1, -1, 0, 0, 3, 17'h00108, 0};
    vt[1] = '{17'h00200, 17'h00040, 16'd1,  3, 5, 0, 8, 17'h00208, 5};
    vt[2] = '{17'h01000, 17'h00040, 16'd3, -1, 0, 4, 3, 17'h01008, 12};
    vt[3] = '{17'h1FFF8, 17'h00010, 16'd2, -1, 0, 1, 3, 17'h00000, 2};

    rst = 1'b1; start = 1'b0; base = '0; stride = '0; num = '0;
    q_ready = '1; out_ready = 1'b0; inj_mask = '0; inj_data = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_qvalid", q_valid, 0);
    chk("rst_qaddr_zero", (q_addr == '0), 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data_zero", (out_data == '0), 1);
`ifdef SNAX_GEMM_READER_PERF_CNT_EN
    chk("rst_stall", stall_cnt, 0);
`endif
    rst = 1'b0;
    tick();

    for (int k = 0; k < 4; k++) begin
      run_vec(vt[k]);
      tick();
    end

    // count == 0: immediate done, nothing issued, never busy
    base = 17'h00500; stride = 17'h40; num = '0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_qvalid", q_valid, 0);
    tick();
    chk("zero_done_once", done, 0);
    chk("zero_still_idle", busy, 0);

    // start while busy is ignored
    g0 = grants[0];
    base = 17'h00300; stride = 17'h40; num = 16'd1; start = 1'b1;
    tick();
    base = 17'h00700; num = 16'd5;
    tick();
    start = 1'b0;
    n = 0;
    while (!out_valid && n < 60) begin tick(); n++; end
    chk("busy_start_ov", out_valid, 1);
    chk("busy_start_data0", out_data[0 +: DW], dfn(17'h00300));
    chk("busy_start_data7", out_data[7*DW +: DW], dfn(17'h00338));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("busy_start_done", done, 1);
    chk("busy_start_idle", busy, 0);
    chk("busy_start_grants", grants[0] - g0, 1);
    tick();

    // reset in REQ with ports 0..3 granted
    q_ready = 8'h0F; base = 17'h00400; stride = 17'h40; num = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("half_granted", q_valid, 8'hF0);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_qvalid", q_valid, 0);
    chk("arst_qaddr_zero", (q_addr == '0), 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_done", done, 0);
    chk("arst_data_zero", (out_data == '0), 1);
    tick();
    rst = 1'b0;
    q_ready = '1;
    inj_mask = 8'h0F;
    inj_data = {NP*DW{1'b1}};
    tick();
    inj_mask = '0;
    tick(); tick();
    chk("late_resp_ignored_ov", out_valid, 0);
    chk("late_resp_ignored_busy", busy, 0);
    chk("late_resp_ignored_data", (out_data == '0), 1);
    run_vec(vt[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/snax_gemm_tcdm_reader.md
Name: snax_gemm_tcdm_reader

Overview:
- Upstream operand-fetch stage for the SNAX GEMM datapath.
- Issues one read per TCDM port per block, honouring per-port q_ready back-pressure, and collects out-of-order per-port responses into a wide word.
- Presents the assembled operand word to the GEMM core over a valid/ready handshake, iterating over a programmed number of strided blocks.

Parameters:
- DataWidth, 64, bits per TCDM port word (multiple of 8).
- NumPorts, 8, TCDM ports driven; output word is NumPorts*DataWidth.
- AddrWidth, 17, TCDM byte-address width.
- CntWidth, 16, width of block count and perf counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- start_i  in  1  one-cycle launch pulse; sampled only in IDLE
- base_addr_i  in  AddrWidth  byte address of block 0, port 0
- stride_i  in  AddrWidth  byte offset between consecutive blocks
- num_blocks_i  in  CntWidth  blocks to fetch
- busy_o  out  1  high from accepted start until done
- done_o  out  1  one-cycle pulse after last block handshake
- tcdm_q_valid_o  out  NumPorts  per-port request valid
- tcdm_q_addr_o  out  NumPorts*AddrWidth  per-port read address
- tcdm_q_ready_i  in  NumPorts  per-port grant
- tcdm_p_valid_i  in  NumPorts  per-port response valid
- tcdm_p_data_i  in  NumPorts*DataWidth  per-port response data
- out_valid_o  out  1  assembled word valid
- out_data_o  out  NumPorts*DataWidth  port i in slice [i*DataWidth +: DataWidth]
- out_ready_i  in  1  GEMM accepts word
- stall_cnt_o  out  CntWidth  only with SNAX_GEMM_READER_PERF_CNT_EN

Behaviour:
- Reset values: busy_o=0, done_o=0, tcdm_q_valid_o=0, tcdm_q_addr_o=0, out_valid_o=0, out_data_o=0, stall_cnt_o=0. Reset mid-operation aborts immediately; in-flight responses arriving after reset are ignored.
- FSM states: IDLE, REQ, OUT.
- IDLE -> REQ on start_i with num_blocks_i!=0. Latch base, stride and count; clear blk=0, granted mask, received mask.
- start_i with num_blocks_i==0: no requests; done_o pulses next cycle; busy_o stays 0.
- start_i while busy is ignored.
- REQ:
  - tcdm_q_valid_o[i] = ~granted[i]. Address[i] = base + blk*stride + i*(DataWidth/8), modulo 2^AddrWidth (wrap, no error).
  - Address is held stable while valid is high.
  - granted[i] sets on q_valid&q_ready.
  - On p_valid[i] with granted[i]&~received[i]: capture data slice and set received[i].
  - p_valid on a non-outstanding port is ignored.
  - Grant and response may fall in the same cycle only for different ports; a response needs ≥1 cycle after its grant.
  - REQ -> OUT in the cycle after received is all-ones.
- OUT:
  - out_valid_o=1; out_data_o is stable until the handshake.
  - On out_valid_o&out_ready_i: if blk==count-1, go to IDLE and pulse done_o next cycle, with busy_o low in that cycle. Otherwise blk++, clear masks, go to REQ.
- No request is issued while in OUT (at most one block in flight).
- Minimum latency per block, with all ports granted immediately and 1-cycle response: start -> out_valid_o is 3 cycles.

Optional Feature:
- Macro: SNAX_GEMM_READER_PERF_CNT_EN.
- Defined: stall_cnt_o counts cycles in REQ with any q_valid high and q_ready low, plus cycles in OUT with out_ready_i low. Cleared on accepted start; saturates at all-ones.
- Undefined: port absent, no counter logic.

Decomposition:
- Package snax_gemm_reader_pkg: FSM state enum, default parameter constants, and a byte-per-word localparam.
- Sub-module snax_gemm_reader_port: per-port grant/receive flags and data capture register, instantiated NumPorts times. The top level holds the FSM, block counter, address generation and the optional counter.

Test Plan:
- Basic fetch: base=0x100, stride=0x40, count=1, all ready, 1-cycle response -> addresses 0x100,0x108..0x138; out_valid_o at cycle 3; data slices match per port; done_o pulses once.
- Per-port back-pressure: port 3 q_ready held low 5 cycles -> port 3 valid and address held stable; other ports request once; out_valid_o only after port 3 response; no duplicate requests.
- Multi-block with output stall: count=3, out_ready_i low 4 cycles per block -> base advances by 0x40 per block; no requests during OUT; 3 handshakes; stall_cnt_o=12 with macro defined.
- Corner cases: count=0 -> done_o next cycle, no q_valid. base=0x1FFF8, stride=0x10 -> port 1 address wraps to 0x00000. start_i while busy -> ignored.
- Reset mid-operation: assert rst_i in REQ with half the ports granted -> all outputs return to reset values asynchronously. After release, a late p_valid is ignored and a fresh start works normally.
